mul8_share_arbiter: RTL and testbench
=====================================

# mul8_share_arbiter

Sequential front-end that time-shares one combinational 8x8 signed (two's-complement) multiplier among NREQ requesters. It arbitrates round-robin, registers the winning operands onto the multiplier inputs, captures the 16-bit product one cycle later, and returns it with the requester ID over a valid/ready response channel. It sits between the requesting datapath blocks and the single shared multiplier instance, which remains purely combinational.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request i has operands pending
- req_ready  out  NREQ  request i accepted this cycle (one-hot or zero)
- req_x  in  8*NREQ  multiplicand for requester i, bits [8i+7:8i], signed
- req_y  in  8*NREQ  multiplier for requester i, bits [8i+7:8i], signed
- mul_x  out  8  registered operand to shared multiplier
- mul_y  out  8  registered operand to shared multiplier
- mul_p  in  16  product from shared multiplier (combinational from mul_x, mul_y)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_p  out  16  signed product
- rsp_id  out  IDW  index of requester that owns rsp_p
- ops_done  out  16  count of completed responses, wraps 0xFFFF->0x0000

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE: if any req_valid, grant winner g, assert req_ready[g], latch req_x/req_y slice g into mul_x/mul_y, latch g into id register, go MUL. Else stay.
- MUL: operands stable on mul_x/mul_y for the full cycle; at end of cycle capture mul_p into rsp_p; go RESP.
- RESP: rsp_valid=1. On rsp_valid&rsp_ready: ops_done+=1; if any req_valid, grant a new winner in the same cycle (same actions as IDLE) and go MUL; else go IDLE. Without rsp_ready: hold rsp_p, rsp_id, rsp_valid; accept nothing.
- Arbitration: round-robin pointer ptr (reset 0). Winner = first i with req_valid[i] searching ptr, ptr+1, ... mod NREQ. After a grant to g, ptr = (g+1) mod NREQ. ptr is unchanged in cycles without a grant.
- req_ready is combinational: at most one bit high, only for a requester whose req_valid is high, and only in IDLE, or in RESP with rsp_ready high. A requester must hold req_x/req_y stable while req_valid is high and not yet accepted.
- Requester index values >= NREQ are never produced on rsp_id.
- Product: rsp_p is the 16-bit two's-complement of signed(x)*signed(y); full range, no saturation.

## Timing
- Reset values: req_ready=0, mul_x=0, mul_y=0, rsp_valid=0, rsp_p=0, rsp_id=0, ops_done=0, ptr=0, state IDLE.
- Accept at cycle T (req_valid[g]&req_ready[g]); mul_x/mul_y valid from T+1; rsp_valid high from T+2.
- Latency 2 cycles accept-to-response. Sustained throughput is one result per 2 cycles with rsp_ready tied high, using the RESP-state back-to-back grant.
- Backpressure: rsp_ready low holds RESP indefinitely; req_ready stays 0 throughout.
- rst asserted in any state: next cycle all outputs at reset values; any in-flight operation is discarded and not counted; ptr returns to 0.
- ops_done increments exactly on rsp_valid&rsp_ready edges.

## Test plan
- After reset, req_valid[2]=1, x=-128 (0x80), y=-128 -> req_ready[2] same cycle; rsp_valid at T+2 with rsp_p=0x4000, rsp_id=2; ops_done=1 after the handshake.
- All four req_valid high continuously, rsp_ready=1, x_i=i+1, y_i=-1 -> grants in order 0,1,2,3,0; rsp_p=0xFFFF,0xFFFE,0xFFFD,0xFFFC; a new response every 2 cycles.
- Requester 1 at x=127, y=127 with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_p=0x3F01, and rsp_id=1 held stable; req_ready=0 for all requesters until rsp_ready rises.
- Only req_valid[3] is active after a grant to requester 3 (ptr=0) -> requester 3 is granted again; ptr wraps to 0 afterwards.
- Assert rst during MUL -> next cycle rsp_valid=0, mul_x=mul_y=0, ops_done unchanged from reset value 0; the discarded product never appears.
- Run 65536 transactions -> ops_done wraps to 0x0000; spot-check products against a signed reference model.

Source files
------------

// File: rtl/mul8_share_arbiter_if.sv
// Handshake bundle between the requesters, the response consumer
// and the shared-multiplier front-end.
interface mul8_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_p;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id
  );
endinterface

// File: rtl/mul8_share_arbiter.sv
// Round-robin front-end time-sharing one combinational 8x8 signed
// multiplier; two cycles from accept to response.
module mul8_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  mul8_share_arbiter_if.slave bus,
  output logic [7:0]  mul_x,
  output logic [7:0]  mul_y,
  input  logic [15:0] mul_p,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] id_q;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;
  logic           rsp_fire;
  logic           grant;

  // first valid requester at or after ptr, wrapping mod NREQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign rsp_fire = (state == RESP) && bus.rsp_ready;
  assign grant    = found && !rst &&
                    ((state == IDLE) || rsp_fire);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    if (rsp_fire)
                 state_nxt = grant ? MUL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win] = 1'b1;
    bus.rsp_valid = (state == RESP);
  end

  assign bus.rsp_id = id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_x     <= '0;
      mul_y     <= '0;
      id_q      <= '0;
      ptr       <= '0;
      bus.rsp_p <= '0;
      ops_done  <= '0;
    end else begin
      if (grant) begin
        mul_x <= bus.req_x[{win, 3'b000} +: 8];
        mul_y <= bus.req_y[{win, 3'b000} +: 8];
        id_q  <= win;
        ptr   <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      end
      if (state == MUL) bus.rsp_p <= mul_p;
      if (rsp_fire) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul8_share_arbiter.sv
// Scoreboard bench for mul8_share_arbiter: directed scenarios,
// a mid-operation reset and a randomized traffic run.
module tb_mul8_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic [15:0] mul_p;
  logic [15:0] ops_done;
  logic [3:0]  v;
  logic [31:0] xs;
  logic [31:0] ys;
  logic        rrdy;

  always #5 clk = ~clk;

  mul8_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  assign bus.req_valid = v;
  assign bus.req_x     = xs;
  assign bus.req_y     = ys;
  assign bus.rsp_ready = rrdy;

  mul8_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mul_x    (mul_x),
    .mul_y    (mul_y),
    .mul_p    (mul_p),
    .ops_done (ops_done)
  );

  function automatic logic [15:0] smul(logic [7:0] a, logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb2;
    sa  = $signed({{8{a[7]}}, a});
    sb2 = $signed({{8{b[7]}}, b});
    return 16'(sa * sb2);
  endfunction

  // the shared multiplier itself
  assign mul_p = smul(mul_x, mul_y);

  typedef struct {
    int          id;
    logic [15:0] p;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          glog[$];
  int          gcyc[$];
  logic [15:0] rlog_p[$];
  int          rlog_id[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int vstart  = 0;
  int n_since = 0;
  int issued  = 0;
  int target  = 0;
  bit in_resp = 0;
  bit auto_rl = 0;
  bit rnd     = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7f;
      2:       return 8'hff;
      3:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  // observe at negedge, drive just after the following posedge
  task automatic tick();
    logic [3:0] hs;
    exp_t       e;
    logic       ok;
    hs = '0;
    @(negedge clk);
    cyc++;
    ok = ((bus.req_ready & ~v) == 4'b0) && $onehot0(bus.req_ready);
    chk("ready_legal", ok, 1'b1);
    if (rst) begin
      sb.delete();
      in_resp = 0;
      n_since = 0;
    end else begin
      if (bus.rsp_valid && !in_resp) begin
        in_resp = 1;
        vstart  = cyc;
      end
      if (bus.rsp_valid && rrdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", bus.rsp_p, 32'hdead);
        end else begin
          e = sb.pop_front();
          chk("rsp_p", bus.rsp_p, e.p);
          chk("rsp_id", bus.rsp_id, e.id);
          chk("latency", vstart - e.cyc, 2);
        end
        rlog_p.push_back(bus.rsp_p);
        rlog_id.push_back(int'(bus.rsp_id));
        n_since++;
        in_resp = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && bus.req_ready[i]) begin
          e.id  = i;
          e.p   = smul(xs[8*i +: 8], ys[8*i +: 8]);
          e.cyc = cyc;
          sb.push_back(e);
          glog.push_back(i);
          gcyc.push_back(cyc);
          hs[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs[i] && !auto_rl) v[i] = 1'b0;
    if (rnd) begin
      rrdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && issued < target &&
            $urandom_range(0, 2) == 0) begin
          v[i]          = 1'b1;
          xs[8*i +: 8]  = rnd_op();
          ys[8*i +: 8]  = rnd_op();
          issued++;
        end
      end
    end
  endtask

  task automatic do_reset();
    v    = '0;
    rrdy = 1'b1;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid || v != 0) &&
           n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < budget, 1'b1);
  endtask

  task automatic gchk(string tag, int k, int id);
    if (glog.size() > k) chk(tag, glog[k], id);
    else chk({tag, "_missing"}, glog.size(), k + 1);
  endtask

  task automatic rchk(string tag, int k, logic [15:0] p, int id);
    if (rlog_p.size() > k) begin
      chk({tag, "_p"}, rlog_p[k], p);
      chk({tag, "_id"}, rlog_id[k], id);
    end else begin
      chk({tag, "_missing"}, rlog_p.size(), k + 1);
    end
  endtask

  initial begin
    int gb;
    int rb;
    int n;
    v    = '0;
    xs   = '0;
    ys   = '0;
    rrdy = 1'b1;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_y", mul_y, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_p", bus.rsp_p, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_ops_done", ops_done, 0);

    // -128 * -128
    gb = glog.size();
    rb = rlog_p.size();
    xs[23:16] = 8'h80;
    ys[23:16] = 8'h80;
    v[2] = 1'b1;
    #1;
    chk("t1_ready", bus.req_ready, 4'b0100);
    drain(20);
    gchk("t1_grant", gb, 2);
    rchk("t1_rsp", rb, 16'h4000, 2);
    chk("t1_ops_done", ops_done, 1);

    // all requesters busy, back-to-back grants
    do_reset();
    gb = glog.size();
    rb = rlog_p.size();
    xs = {8'd4, 8'd3, 8'd2, 8'd1};
    ys = 32'hffff_ffff;
    auto_rl = 1;
    v = 4'hf;
    n = 0;
    while (glog.size() < gb + 5 && n < 40) begin
      tick();
      n++;
    end
    v = '0;
    auto_rl = 0;
    drain(20);
    gchk("t2_g0", gb,     0);
    gchk("t2_g1", gb + 1, 1);
    gchk("t2_g2", gb + 2, 2);
    gchk("t2_g3", gb + 3, 3);
    gchk("t2_g4", gb + 4, 0);
    if (gcyc.size() >= gb + 5)
      for (int k = 0; k < 4; k++)
        chk("t2_gap", gcyc[gb+k+1] - gcyc[gb+k], 2);
    rchk("t2_r0", rb,     16'hffff, 0);
    rchk("t2_r1", rb + 1, 16'hfffe, 1);
    rchk("t2_r2", rb + 2, 16'hfffd, 2);
    rchk("t2_r3", rb + 3, 16'hfffc, 3);
    rchk("t2_r4", rb + 4, 16'hffff, 0);

    // backpressure holds the response and blocks grants
    do_reset();
    gb = glog.size();
    rrdy = 1'b0;
    xs[15:8] = 8'h7f;
    ys[15:8] = 8'h7f;
    v[1] = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t3_wait", n < 10, 1'b1);
    xs[7:0]   = 8'd3;
    ys[7:0]   = 8'd5;
    xs[23:16] = 8'd4;
    ys[23:16] = 8'd6;
    v[0] = 1'b1;
    v[2] = 1'b1;
    repeat (5) begin
      tick();
      chk("t3_valid", bus.rsp_valid, 1);
      chk("t3_p", bus.rsp_p, 16'h3f01);
      chk("t3_id", bus.rsp_id, 1);
      chk("t3_ready", bus.req_ready, 0);
    end
    rrdy = 1'b1;
    drain(20);
    gchk("t3_g0", gb,     1);
    gchk("t3_g1", gb + 1, 2);
    gchk("t3_g2", gb + 2, 0);
    chk("t3_ops_done", ops_done, 3);

    // lone requester 3 regranted; pointer wraps to 0
    do_reset();
    gb = glog.size();
    xs[31:24] = 8'd9;
    ys[31:24] = 8'hfd;
    v[3] = 1'b1;
    drain(20);
    xs[31:24] = 8'hf7;
    v[3] = 1'b1;
    drain(20);
    xs[7:0] = 8'd2;
    ys[7:0] = 8'd3;
    v = 4'b1001;
    drain(20);
    gchk("t4_g0", gb,     3);
    gchk("t4_g1", gb + 1, 3);
    gchk("t4_g2", gb + 2, 0);
    gchk("t4_g3", gb + 3, 3);

    // reset while an operation is in MUL
    do_reset();
    xs[15:8] = 8'd5;
    ys[15:8] = 8'd7;
    v[1] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", bus.rsp_valid, 0);
    chk("t5_mul_x", mul_x, 0);
    chk("t5_mul_y", mul_y, 0);
    chk("t5_ops_done", ops_done, 0);
    repeat (6) tick();
    chk("t5_no_rsp", bus.rsp_valid, 0);
    chk("t5_ops_after", ops_done, 0);

    // random traffic with random backpressure
    do_reset();
    issued = 0;
    target = 1500;
    rnd = 1;
    n = 0;
    while (issued < target && n < 20000) begin
      tick();
      n++;
    end
    chk("rnd_timeout", n < 20000, 1'b1);
    rnd = 0;
    rrdy = 1'b1;
    drain(200);
    chk("rnd_count", n_since, issued);
    chk("rnd_ops_done", ops_done, 16'(n_since));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
